cordic_sincos: RTL and testbench

//  Inverse companion to the arctan pitch block: converts a signed pitch angle into unit-gravity
//  y/z accelerometer components, y = sin(angle) and z = cos(angle), in the accel data format.

---
 rtl/cordic_sincos.sv | 272 +++++++++++++++++++++++++++
 tb/tb_cordic_sincos.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sincos.sv
// -----------------------------------------------------------------------------
// cordic_sincos
//
// Converts a signed pitch angle into unit-gravity y/z accelerometer components,
// y = sin(angle) and z = cos(angle), using an iterative rotation-mode CORDIC
// (one micro-rotation per clock) behind a start/busy/done handshake.
//
// Ports
//   clk       in   1       system clock, rising edge
//   rst       in   1       synchronous reset, active-high
//   start     in   1       request strobe, honoured only in IDLE or DONE
//   angle_in  in   DATA_W  signed angle, Q2.13 radians (pi = 25736)
//   busy      out  1       high while in LOAD or ROTATE
//   done      out  1       one-cycle pulse when y_out/z_out update
//   y_out     out  DATA_W  signed sin(angle), Q1.14 (1.0 = 16384)
//   z_out     out  DATA_W  signed cos(angle), Q1.14
//
// Timing: start sampled at edge 0 -> LOAD work at edge 1 -> rotations at
// edges 2..ITERATIONS+1 -> result registered (done=1) at edge ITERATIONS+2.
// -----------------------------------------------------------------------------
module cordic_sincos #(
    parameter int DATA_W     = 16,
    parameter int ITERATIONS = 14,
    parameter int GUARD      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] angle_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] y_out,
    output logic [DATA_W-1:0] z_out
);

    // Internal datapath width: one extra bit over the guarded data width so
    // the CORDIC gain growth and the folded angle never overflow.
    localparam int IW = DATA_W + GUARD + 1;
    localparam int CW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

    localparam logic signed [DATA_W:0] PI_C      = (DATA_W+1)'(25736);
    localparam logic signed [DATA_W:0] NEG_PI_C  = -PI_C;
    localparam logic signed [DATA_W:0] HPI_C     = (DATA_W+1)'(12868);
    localparam logic signed [DATA_W:0] NEG_HPI_C = -HPI_C;

    // Start vector x = K * 1.0 so no gain correction is needed at the end.
    localparam logic signed [IW-1:0] X_INIT_C  = IW'(9949 << GUARD);
    localparam logic signed [IW-1:0] RND_C     = IW'(1 << (GUARD - 1));
    localparam logic signed [IW-1:0] ONE_C     = IW'(1 << (DATA_W - 2));
    localparam logic signed [IW-1:0] NEG_ONE_C = -ONE_C;
    localparam logic [CW-1:0]        LAST_IT_C = CW'(ITERATIONS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_ROTATE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            iter_q, iter_d;
    logic [DATA_W-1:0]        angle_q, angle_d;
    logic                     neg_q, neg_d;
    logic signed [IW-1:0]     x_q, x_d;
    logic signed [IW-1:0]     y_q, y_d;
    logic signed [IW-1:0]     z_q, z_d;
    logic [DATA_W-1:0]        y_out_q, y_out_d;
    logic [DATA_W-1:0]        z_out_q, z_out_d;
    logic                     done_q, done_d;

    // -------------------------------------------------------------------------
    // Arctangent ROM: round(atan(2^-i) * 2^(13+GUARD)). Entries are scaled for
    // GUARD = 2 (angle LSB of 2^-15 rad inside the datapath).
    // -------------------------------------------------------------------------
    function automatic logic signed [IW-1:0] atan_rom(input logic [CW-1:0] idx);
        case (int'(idx))
            0:       return IW'(25736);
            1:       return IW'(15193);
            2:       return IW'(8027);
            3:       return IW'(4075);
            4:       return IW'(2045);
            5:       return IW'(1024);
            6:       return IW'(512);
            7:       return IW'(256);
            8:       return IW'(128);
            9:       return IW'(64);
            10:      return IW'(32);
            11:      return IW'(16);
            12:      return IW'(8);
            13:      return IW'(4);
            14:      return IW'(2);
            15:      return IW'(1);
            default: return '0;
        endcase
    endfunction

    // Saturate a rounded result to +/-1.0 in the output format.
    function automatic logic [DATA_W-1:0] sat_unit(input logic signed [IW-1:0] v);
        if (v > ONE_C) begin
            return ONE_C[DATA_W-1:0];
        end else if (v < NEG_ONE_C) begin
            return NEG_ONE_C[DATA_W-1:0];
        end else begin
            return v[DATA_W-1:0];
        end
    endfunction

    // -------------------------------------------------------------------------
    // LOAD datapath: clamp to [-pi, pi] then fold into [-pi/2, pi/2]. The fold
    // by pi negates both sin and cos, which is undone in the DONE cycle.
    // -------------------------------------------------------------------------
    logic signed [DATA_W:0] ang_s;
    logic signed [DATA_W:0] ang_clamp;
    logic signed [DATA_W:0] ang_fold;
    logic                   neg_fold;
    logic signed [IW-1:0]   z_init;

    assign ang_s = {angle_q[DATA_W-1], angle_q};

    always_comb begin
        ang_clamp = ang_s;
        if (ang_s > PI_C) begin
            ang_clamp = PI_C;
        end else if (ang_s < NEG_PI_C) begin
            ang_clamp = NEG_PI_C;
        end
    end

    always_comb begin
        ang_fold = ang_clamp;
        neg_fold = 1'b0;
        if (ang_clamp > HPI_C) begin
            ang_fold = ang_clamp - PI_C;
            neg_fold = 1'b1;
        end else if (ang_clamp < NEG_HPI_C) begin
            ang_fold = ang_clamp + PI_C;
            neg_fold = 1'b1;
        end
    end

    assign z_init = IW'(ang_fold) <<< GUARD;

    // -------------------------------------------------------------------------
    // ROTATE datapath: one micro-rotation, direction chosen by the sign of the
    // residual angle (z >= 0 rotates positively).
    // -------------------------------------------------------------------------
    logic                 d_pos;
    logic signed [IW-1:0] x_sh;
    logic signed [IW-1:0] y_sh;
    logic signed [IW-1:0] atan_val;
    logic signed [IW-1:0] x_rot;
    logic signed [IW-1:0] y_rot;
    logic signed [IW-1:0] z_rot;

    assign d_pos    = ~z_q[IW-1];
    assign x_sh     = x_q >>> iter_q;
    assign y_sh     = y_q >>> iter_q;
    assign atan_val = atan_rom(iter_q);
    assign x_rot    = d_pos ? (x_q - y_sh) : (x_q + y_sh);
    assign y_rot    = d_pos ? (y_q + x_sh) : (y_q - x_sh);
    assign z_rot    = d_pos ? (z_q - atan_val) : (z_q + atan_val);

    // -------------------------------------------------------------------------
    // DONE datapath: drop guard bits with round-half-up, undo the fold, clamp.
    // -------------------------------------------------------------------------
    logic signed [IW-1:0] y_rnd;
    logic signed [IW-1:0] x_rnd;
    logic signed [IW-1:0] y_sgn;
    logic signed [IW-1:0] x_sgn;

    assign y_rnd = (y_q + RND_C) >>> GUARD;
    assign x_rnd = (x_q + RND_C) >>> GUARD;
    assign y_sgn = neg_q ? -y_rnd : y_rnd;
    assign x_sgn = neg_q ? -x_rnd : x_rnd;

    // -------------------------------------------------------------------------
    // Next-state / next-data logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        angle_d = angle_q;
        neg_d   = neg_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        y_out_d = y_out_q;
        z_out_d = z_out_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    angle_d = angle_in;
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                x_d     = X_INIT_C;
                y_d     = '0;
                z_d     = z_init;
                neg_d   = neg_fold;
                iter_d  = '0;
                state_d = S_ROTATE;
            end

            S_ROTATE: begin
                x_d = x_rot;
                y_d = y_rot;
                z_d = z_rot;
                if (iter_q == LAST_IT_C) begin
                    iter_d  = '0;
                    state_d = S_DONE;
                end else begin
                    iter_d = iter_q + 1'b1;
                end
            end

            S_DONE: begin
                y_out_d = sat_unit(y_sgn);
                z_out_d = sat_unit(x_sgn);
                done_d  = 1'b1;
                if (start) begin
                    angle_d = angle_in;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            angle_q <= '0;
            neg_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            y_out_q <= '0;
            z_out_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            angle_q <= angle_d;
            neg_q   <= neg_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            y_out_q <= y_out_d;
            z_out_q <= z_out_d;
            done_q  <= done_d;
        end
    end

    assign busy  = (state_q == S_LOAD) || (state_q == S_ROTATE);
    assign done  = done_q;
    assign y_out = y_out_q;
    assign z_out = z_out_q;

endmodule

// File: tb/tb_cordic_sincos.sv
// -----------------------------------------------------------------------------
// tb_cordic_sincos
//
// Self-checking bench for cordic_sincos. Expected results come from ideal
// real-valued sin/cos of the clamped input angle, rounded to Q1.14 and
// saturated at +/-1.0, compared with a +/-4 LSB tolerance. Handshake timing
// (16-cycle latency, single-cycle done, start ignored while busy, start held
// through DONE, mid-run reset) is checked against fixed cycle counts.
// -----------------------------------------------------------------------------
module tb_cordic_sincos;

    localparam int LAT = 16;
    localparam int TOL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] angle_in;
    logic        busy;
    logic        done;
    logic [15:0] y_out;
    logic [15:0] z_out;

    int pass_cnt  = 0;
    int check_cnt = 0;

    cordic_sincos #(
        .DATA_W    (16),
        .ITERATIONS(14),
        .GUARD     (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .angle_in(angle_in),
        .busy    (busy),
        .done    (done),
        .y_out   (y_out),
        .z_out   (z_out)
    );

    always #5 clk = ~clk;

    // Global time limit so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input int obs, input int exp, input int tol);
        check_cnt++;
        if (obs >= exp - tol && obs <= exp + tol) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d, want %0d (+/-%0d)", tag, obs, exp, tol);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int clamp_angle(input int a);
        if (a > 25736)  return 25736;
        if (a < -25736) return -25736;
        return a;
    endfunction

    function automatic int to_q14(input real v);
        real r;
        int  q;
        r = v * 16384.0;
        q = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
        if (q > 16384)  q = 16384;
        if (q < -16384) q = -16384;
        return q;
    endfunction

    function automatic int ref_sin(input int a);
        return to_q14($sin(real'(clamp_angle(a)) / 8192.0));
    endfunction

    function automatic int ref_cos(input int a);
        return to_q14($cos(real'(clamp_angle(a)) / 8192.0));
    endfunction

    function automatic int sval(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic launch(input int ang);
        angle_in = 16'(ang);
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    // Counts edges after the launch edge until done is seen; -1 on timeout.
    task automatic wait_done(output int lat, output logic busy_first);
        lat        = -1;
        busy_first = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 1) busy_first = busy;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_check(input int ang, input string tag);
        int          lat;
        logic        bf;
        logic [15:0] y_hold;
        logic [15:0] z_hold;
        launch(ang);
        wait_done(lat, bf);
        check_val({tag, "_latency"}, lat, LAT, 0);
        check_val({tag, "_busy"}, int'(bf), 1, 0);
        check_val({tag, "_y"}, sval(y_out), ref_sin(ang), TOL);
        check_val({tag, "_z"}, sval(z_out), ref_cos(ang), TOL);
        $display("run %s angle=%0d y=%0d z=%0d lat=%0d", tag, ang, sval(y_out), sval(z_out), lat);
        y_hold = y_out;
        z_hold = z_out;
        @(posedge clk); #1;
        check_val({tag, "_done_pulse"}, int'(done), 0, 0);
        check_val({tag, "_y_hold"}, sval(y_out), sval(y_hold), 0);
        check_val({tag, "_z_hold"}, sval(z_out), sval(z_hold), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          lat;
        int          ndone;
        int          ang;
        logic        bf;
        logic [15:0] rv;

        rst      = 1'b1;
        start    = 1'b0;
        angle_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_busy", int'(busy), 0, 0);
        check_val("reset_done", int'(done), 0, 0);
        check_val("reset_y", sval(y_out), 0, 0);
        check_val("reset_z", sval(z_out), 0, 0);

        // Reset must win over a simultaneous start.
        angle_in = 16'(4289);
        start    = 1'b1;
        @(posedge clk); #1;
        check_val("rst_over_start_busy", int'(busy), 0, 0);
        start = 1'b0;
        rst   = 1'b0;
        @(posedge clk); #1;
        check_val("idle_after_rst_busy", int'(busy), 0, 0);

        // Directed angles: principal, boundaries, folded, clamped.
        run_check(4289,   "pi_6");
        run_check(8578,   "pi_3");
        run_check(0,      "zero");
        run_check(12868,  "pos_half_pi");
        run_check(-12868, "neg_half_pi");
        run_check(17157,  "two_pi_3");
        run_check(-25736, "neg_pi");
        run_check(25736,  "pos_pi");
        run_check(32767,  "clamp_pos");
        run_check(-32768, "clamp_neg");
        run_check(-4289,  "neg_pi_6");

        // start re-asserted with a new angle while busy: ignored entirely.
        angle_in = 16'(4289);
        start    = 1'b1;
        @(posedge clk); #1;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            start    = (k <= 12);
            angle_in = 16'(8578);
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        check_val("busy_ignore_latency", lat, LAT, 0);
        check_val("busy_ignore_y", sval(y_out), ref_sin(4289), TOL);
        check_val("busy_ignore_z", sval(z_out), ref_cos(4289), TOL);
        $display("run busy_ignore angle=4289 y=%0d z=%0d lat=%0d", sval(y_out), sval(z_out), lat);
        ndone = 0;
        repeat (24) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check_val("busy_ignore_single_done", ndone, 0, 0);

        // start held through DONE: back-to-back run, second done 16 later.
        angle_in = 16'(4289);
        start    = 1'b1;
        @(posedge clk); #1;
        angle_in = 16'(8578);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        check_val("b2b_first_latency", lat, LAT, 0);
        check_val("b2b_first_y", sval(y_out), ref_sin(4289), TOL);
        check_val("b2b_first_z", sval(z_out), ref_cos(4289), TOL);
        $display("run b2b_first angle=4289 y=%0d z=%0d lat=%0d", sval(y_out), sval(z_out), lat);
        wait_done(lat, bf);
        check_val("b2b_second_latency", lat, LAT, 0);
        check_val("b2b_second_y", sval(y_out), ref_sin(8578), TOL);
        check_val("b2b_second_z", sval(z_out), ref_cos(8578), TOL);
        $display("run b2b_second angle=8578 y=%0d z=%0d lat=%0d", sval(y_out), sval(z_out), lat);
        @(posedge clk); #1;

        // Reset during ROTATE iteration 5 (edge 7 after the launch edge).
        launch(4289);
        repeat (6) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("midrst_busy", int'(busy), 0, 0);
        check_val("midrst_done", int'(done), 0, 0);
        check_val("midrst_y", sval(y_out), 0, 0);
        check_val("midrst_z", sval(z_out), 0, 0);
        $display("run midrst busy=%0d done=%0d y=%0d z=%0d", busy, done, sval(y_out), sval(z_out));
        rst = 1'b0;
        @(posedge clk); #1;
        run_check(4289, "after_rst");

        // Randomised angles: half over the whole 16-bit range (exercises the
        // clamp), half inside +/-pi.
        for (int n = 0; n < 30; n++) begin
            if (n % 2 == 0) begin
                rv  = 16'($urandom_range(0, 65535));
                ang = sval(rv);
            end else begin
                ang = int'($urandom_range(0, 51472)) - 25736;
            end
            run_check(ang, $sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
